// File: rtl/distortion_sched.sv
// distortion_sched: round-robin scheduler sharing one distortion core between channels A and B.
// Optional DISTORTION_SCHED_BYPASS_EN adds input byp, which returns the request data instead of core_out.
module distortion_sched #(
  parameter int WIDTH = 8,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
`ifdef DISTORTION_SCHED_BYPASS_EN
  input  logic             byp,
`endif
  input  logic             req_a_valid,
  input  logic             req_b_valid,
  input  logic [WIDTH-1:0] req_a_data,
  input  logic [WIDTH-1:0] req_b_data,
  output logic             req_a_ready,
  output logic             req_b_ready,
  output logic [WIDTH-1:0] core_in,
  input  logic [WIDTH-1:0] core_out,
  output logic             res_a_valid,
  output logic             res_b_valid,
  output logic [WIDTH-1:0] res_a_data,
  output logic [WIDTH-1:0] res_b_data,
  input  logic             res_a_ready,
  input  logic             res_b_ready
);
  logic busy_a, busy_b, last_b;
  logic elig_a, elig_b, gnt_a, gnt_b, cap_a, cap_b;
  logic [LAT:0] tag_v, tag_c;
  logic [WIDTH-1:0] res_val;
  assign elig_a = req_a_valid & ~busy_a;
  assign elig_b = req_b_valid & ~busy_b;
  // last_b set means B won the previous accept, so A takes the next contention
  assign gnt_a = ~rst & elig_a & (~elig_b | last_b);
  assign gnt_b = ~rst & elig_b & (~elig_a | ~last_b);
  assign req_a_ready = gnt_a;
  assign req_b_ready = gnt_b;
  assign cap_a = tag_v[LAT] & ~tag_c[LAT];
  assign cap_b = tag_v[LAT] & tag_c[LAT];
`ifdef DISTORTION_SCHED_BYPASS_EN
  logic [LAT:0] tag_byp;
  logic [WIDTH-1:0] tag_data [LAT+1];
  assign res_val = tag_byp[LAT] ? tag_data[LAT] : core_out;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_byp <= '0;
      for (int i = 0; i <= LAT; i++) tag_data[i] <= '0;
    end else begin
      tag_byp <= {tag_byp[LAT-1:0], byp};
      tag_data[0] <= gnt_a ? req_a_data : req_b_data;
      for (int i = 1; i <= LAT; i++) tag_data[i] <= tag_data[i-1];
    end
  end
`else
  assign res_val = core_out;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_a      <= 1'b0;
      busy_b      <= 1'b0;
      last_b      <= 1'b1;
      tag_v       <= '0;
      tag_c       <= '0;
      core_in     <= '0;
      res_a_valid <= 1'b0;
      res_b_valid <= 1'b0;
      res_a_data  <= '0;
      res_b_data  <= '0;
    end else begin
      busy_a      <= gnt_a ? 1'b1 : (res_a_valid & res_a_ready) ? 1'b0 : busy_a;
      busy_b      <= gnt_b ? 1'b1 : (res_b_valid & res_b_ready) ? 1'b0 : busy_b;
      last_b      <= (gnt_a | gnt_b) ? gnt_b : last_b;
      tag_v       <= {tag_v[LAT-1:0], gnt_a | gnt_b};
      tag_c       <= {tag_c[LAT-1:0], gnt_b};
      core_in     <= gnt_a ? req_a_data : gnt_b ? req_b_data : '0;
      res_a_valid <= cap_a ? 1'b1 : res_a_ready ? 1'b0 : res_a_valid;
      res_b_valid <= cap_b ? 1'b1 : res_b_ready ? 1'b0 : res_b_valid;
      res_a_data  <= cap_a ? res_val : res_a_data;
      res_b_data  <= cap_b ? res_val : res_b_data;
    end
  end
endmodule

// File: doc/distortion_sched.md
DISTORTION_SCHED -- requirements
Module: distortion_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the sample width in bits.
REQ-002 The block SHALL have parameter LAT, default 2, giving the shared distortion core latency in cycles from core_in to core_out (range 1..8).
REQ-003 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Ports req_a_valid, req_b_valid  input  1  channel A/B sample offered.
REQ-006 Ports req_a_data, req_b_data  input  WIDTH  channel A/B sample.
REQ-007 Ports req_a_ready, req_b_ready  output  1  channel A/B sample accepted this cycle when valid is high.
REQ-008 Port core_in  output  WIDTH  registered sample driven to the shared core.
REQ-009 Port core_out  input  WIDTH  core result, LAT cycles after core_in.
REQ-010 Ports res_a_valid, res_b_valid  output  1  result held for channel A/B.
REQ-011 Ports res_a_data, res_b_data  output  WIDTH  channel A/B result.
REQ-012 Ports res_a_ready, res_b_ready  input  1  consumer takes result.

Function
REQ-013 Accept on channel x SHALL occur in the cycle where req_x_valid and req_x_ready are both high.
REQ-014 Per-channel busy flag SHALL set on accept and clear on res_x_valid and res_x_ready; at most one sample per channel SHALL be outstanding.
REQ-015 req_x_ready SHALL be low while busy_x is set; at most one of req_a_ready, req_b_ready SHALL be high per cycle.
REQ-016 When both channels are non-busy and valid, grant SHALL go to the channel not granted last (round-robin pointer updates only on accept).
REQ-017 When only one channel is eligible (valid and non-busy), it SHALL be granted regardless of the pointer; ready MAY depend combinationally on the valids.
REQ-018 On accept, core_in SHALL load the accepted data at that clock edge; in cycles without accept core_in SHALL load zero.
REQ-019 A tag pipeline of LAT+1 stages SHALL carry {valid, channel} alongside the sample so the tag aligns with core_out.
REQ-020 When the aligned tag is valid, core_out SHALL be captured into res_x_data of the tagged channel and res_x_valid SHALL be set; accept in cycle N gives res_x_valid in cycle N+LAT+2 (4 at default).
REQ-021 res_x_valid and res_x_data SHALL hold stable until res_x_ready is high; res_x_valid SHALL then clear at the next edge.
REQ-022 busy_x cleared in cycle N SHALL allow req_x_ready in cycle N+1 at the earliest; full pipelining of A and B on alternating cycles SHALL be supported.
REQ-023 core_out SHALL be ignored in cycles whose aligned tag is invalid.

Reset
REQ-024 While rst is high: req ready, res valid, res data, core_in, tag pipeline, busy flags SHALL be zero; the round-robin pointer SHALL make channel A win the first contention.
REQ-025 Reset mid-operation SHALL discard all in-flight samples; no res_x_valid SHALL assert after deassertion until a new accept completes.

Configuration
REQ-026 With macro DISTORTION_SCHED_BYPASS_EN defined, the block SHALL have input byp (1 bit); byp sampled at accept SHALL travel in the tag, and result data SHALL be the original request data instead of core_out, with identical latency.
REQ-027 Without DISTORTION_SCHED_BYPASS_EN, port byp and the data field of the tag SHALL not exist; results SHALL always come from core_out.

Verification
REQ-028 Single A: req_a_valid=1 data 0x5A in cycle 0, core model echo LAT=2 -> core_in=0x5A cycle 1, res_a_valid=1 data 0x5A cycle 4, res_b_valid stays 0.
REQ-029 Contention: both valid from cycle 0 after reset, res ready tied high -> grants A cycle 0, B cycle 1; A not re-granted before res_a handshake.
REQ-030 Backpressure: res_a_ready=0 for 10 cycles -> res_a_data stable, req_a_ready=0 throughout, B traffic unaffected.
REQ-031 Reset: assert rst in cycle 2 after A accept at cycle 0 -> all outputs 0 immediately, no res_a_valid ever follows.
REQ-032 Bypass (macro defined): byp=1, data 0x80, core returns 0x7F -> res_a_data=0x80 at cycle 4; byp=0 -> 0x7F.
REQ-033 LAT=5 build: single B accept at cycle 0 -> res_b_valid at cycle 7.
